// File: rtl/mux_arb_if.sv
// Requester/result handshake bundle for mux_arb.
// The master side is the requester/consumer environment; the slave side is the arbiter.
interface mux_arb_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 31,
  parameter int ID_W       = 1
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_op1;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_op2;
  logic                          res_valid;
  logic                          res_ready;
  logic [DATA_WIDTH-1:0]         res_data;
  logic                          res_eq;
  logic [ID_W-1:0]               res_id;

  modport master (
    output req_valid, req_op1, req_op2, res_ready,
    input  req_ready, res_valid, res_data, res_eq, res_id
  );

  modport slave (
    input  req_valid, req_op1, req_op2, res_ready,
    output req_ready, res_valid, res_data, res_eq, res_id
  );
endinterface

// File: rtl/mux_arb.sv
// Round-robin arbiter feeding one shared compare-select stage:
// grant a requester, capture its operands, emit (op1 == op2) ? op1 : op2 with its id.
module mux_arb #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 31,
  parameter int ID_W       = 1
) (
  input  logic       aclk,
  input  logic       arst,
  mux_arb_if.slave   bus,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_t;

  localparam int              IW1  = ID_W + 1;
  localparam logic [ID_W:0]   NR_W = IW1'(NUM_REQ);

  state_t                              state_q, state_d;
  logic [ID_W-1:0]                     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]                     id_q, id_d;
  logic [ID_W-1:0]                     res_id_q, res_id_d;
  logic [DATA_WIDTH-1:0]               op1_q, op1_d, op2_q, op2_d;
  logic [DATA_WIDTH-1:0]               res_data_q, res_data_d;
  logic                                res_eq_q, res_eq_d;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  op1_arr, op2_arr;
  logic [2*NUM_REQ-1:0]                vv;
  logic [NUM_REQ-1:0]                  rot, grant;
  logic [ID_W:0]                       ofs, sum;
  logic [ID_W-1:0]                     win_id;
  logic                                any_grant, accept, sel;

  assign op1_arr = bus.req_op1;
  assign op2_arr = bus.req_op2;

  // Rotate valids so bit j is requester (rr_ptr+1+j) mod NUM_REQ; lowest set bit wins.
  always_comb begin
    ofs       = {1'b0, rr_ptr_q} + 1'b1;
    vv        = {bus.req_valid, bus.req_valid} >> ofs;
    rot       = vv[NUM_REQ-1:0];
    any_grant = |rot;
    sum       = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) sum = ofs + IW1'(j);
    end
    if (sum >= NR_W) sum = sum - NR_W;
    win_id = sum[ID_W-1:0];
    grant  = any_grant ? (NUM_REQ'(1) << win_id) : '0;
  end

  assign accept = (state_q == IDLE) && any_grant && !arst;

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= ID_W'(NUM_REQ - 1);
      id_q       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      res_data_q <= '0;
      res_eq_q   <= 1'b0;
      res_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      res_data_q <= res_data_d;
      res_eq_q   <= res_eq_d;
      res_id_q   <= res_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    state_d = RESP;
      RESP:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    res_data_d = res_data_q;
    res_eq_d   = res_eq_q;
    res_id_d   = res_id_q;
    sel        = (op1_q == op2_q);
    if (accept) begin
      op1_d    = op1_arr[win_id];
      op2_d    = op2_arr[win_id];
      id_d     = win_id;
      rr_ptr_d = win_id;
    end
    if (state_q == CALC) begin
      res_data_d = sel ? op1_q : op2_q;
      res_eq_d   = sel;
      res_id_d   = id_q;
    end
  end

  // Grant is withheld while reset is asserted, even though the state already reads IDLE.
  always_comb begin
    bus.req_ready = (state_q == IDLE && !arst) ? grant : '0;
    bus.res_valid = (state_q == RESP);
    bus.res_data  = res_data_q;
    bus.res_eq    = res_eq_q;
    bus.res_id    = res_id_q;
    busy          = (state_q != IDLE);
  end

endmodule
